multicycle_control_unit: RTL

Multi-cycle successor to the single-cycle RISC-V control unit. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared datapath's register-write, ALU, immediate, PC and memory controls. It handshakes with a single instruction/data memory port that may stall, and decodes the full RV32I ALU, load/store, branch, JAL/JALR and LUI subset. It sits between the unified memory interface and the datapath (register file, ALU, PC register).

---
 rtl/multicycle_control_unit.sv | 225 ++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// rtl/multicycle_control_unit.sv - multi-cycle RV32I control FSM with a stallable unified memory port
module multicycle_control_unit #(
    parameter int DATA_WIDTH    = 32,
    parameter bit EN_BRANCH_EXT = 1'b1,
    parameter int MEM_TIMEOUT   = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic                  mem_ready,
    input  logic                  EQ,
    input  logic                  LT,
    input  logic                  LTU,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic                  AdrSrc,
    output logic                  RegWrite,
    output logic [3:0]            ALUctrl,
    output logic                  ALUsrc,
    output logic [2:0]            ImmSrc,
    output logic                  PCwrite,
    output logic [1:0]            PCsrc,
    output logic [1:0]            ResultSrc,
    output logic                  retire,
    output logic                  trap,
    output logic [1:0]            trap_cause,
    output logic [2:0]            state
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    localparam logic [3:0] ALU_SUM = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3,
                           ALU_XOR = 4'd4, ALU_SLL = 4'd5, ALU_SRL = 4'd6, ALU_SRA = 4'd7,
                           ALU_SLT = 4'd8, ALU_SLTU = 4'd9;
    localparam logic [2:0] IMM_I = 3'd0, IMM_S = 3'd1, IMM_B = 3'd2, IMM_U = 3'd3, IMM_J = 3'd4;
    localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

    state_t      st, st_nxt;
    logic [31:0] ir;
    logic [7:0]  tmo_cnt;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, is_lui;
    logic       br_legal, legal, br_taken, stalled, timed_out, req;
    logic [3:0] alu_op;
    logic       unused_ir;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign funct7b5  = ir[30];
    assign unused_ir = ^{ir[31], ir[29:15], ir[11:7]};

    assign is_r      = (opcode == 7'b0110011);
    assign is_i      = (opcode == 7'b0010011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_branch = (opcode == 7'b1100011);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_lui    = (opcode == 7'b0110111);

    // funct3 010/011 are not branches at all; 1xx are the extended compares
    assign br_legal = (funct3[2:1] == 2'b00) || (EN_BRANCH_EXT && funct3[2]);
    assign legal    = is_r || is_i || is_load || is_store || (is_branch && br_legal)
                    || is_jal || is_jalr || is_lui;

    always_comb begin
        alu_op = ALU_SUM;
        case (funct3)
            3'b000:  alu_op = (is_r && funct7b5) ? ALU_SUB : ALU_SUM;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = EQ;
            3'b001:  br_taken = !EQ;
            3'b100:  br_taken = LT;
            3'b101:  br_taken = !LT;
            3'b110:  br_taken = LTU;
            3'b111:  br_taken = !LTU;
            default: br_taken = 1'b0;
        endcase
    end

    assign req       = (st == S_FETCH) || (st == S_MEM);
    assign stalled   = req && !mem_ready;
    assign timed_out = stalled && ((tmo_cnt + 8'd1) == TMO_LIMIT);

    always_comb begin
        st_nxt = st;
        case (st)
            S_FETCH:  if (mem_ready) st_nxt = S_DECODE;
                      else if (timed_out) st_nxt = S_TRAP;
            S_DECODE: if (!legal) st_nxt = S_TRAP;
                      else if (is_lui) st_nxt = S_WB;
                      else st_nxt = S_EXEC;
            S_EXEC:   if (is_r || is_i) st_nxt = S_WB;
                      else if (is_load || is_store) st_nxt = S_MEM;
                      else st_nxt = S_FETCH;
            S_MEM:    if (mem_ready) st_nxt = is_load ? S_WB : S_FETCH;
                      else if (timed_out) st_nxt = S_TRAP;
            S_WB:     st_nxt = S_FETCH;
            default:  st_nxt = S_TRAP;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= S_FETCH;
            ir         <= '0;
            tmo_cnt    <= '0;
            trap       <= 1'b0;
            trap_cause <= 2'd0;
        end else begin
            st <= st_nxt;
            if (st == S_FETCH && mem_ready)
                ir <= instr[31:0];
            if (mem_ready || st_nxt != st)
                tmo_cnt <= '0;
            else if (stalled)
                tmo_cnt <= tmo_cnt + 8'd1;
            if (st == S_DECODE && !legal) begin
                trap       <= 1'b1;
                trap_cause <= 2'd1;
            end else if (timed_out) begin
                trap       <= 1'b1;
                trap_cause <= 2'd2;
            end
        end
    end

    // Moore outputs from state and IR; branch PCsrc and MEM completion follow live inputs
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        AdrSrc    = 1'b0;
        RegWrite  = 1'b0;
        ALUctrl   = ALU_SUM;
        ALUsrc    = 1'b0;
        ImmSrc    = IMM_I;
        PCwrite   = 1'b0;
        PCsrc     = 2'd0;
        ResultSrc = 2'd0;
        retire    = 1'b0;
        case (st)
            S_FETCH: mem_req = 1'b1;
            S_EXEC: begin
                if (is_r || is_i) begin
                    ALUctrl = alu_op;
                    ALUsrc  = is_i;
                end else if (is_load || is_store) begin
                    ALUsrc = 1'b1;
                    ImmSrc = is_store ? IMM_S : IMM_I;
                end else if (is_branch) begin
                    ALUctrl = ALU_SUB;
                    ImmSrc  = IMM_B;
                    PCwrite = 1'b1;
                    PCsrc   = br_taken ? 2'd1 : 2'd0;
                    retire  = 1'b1;
                end else if (is_jal) begin
                    ImmSrc    = IMM_J;
                    ResultSrc = 2'd2;
                    RegWrite  = 1'b1;
                    PCwrite   = 1'b1;
                    PCsrc     = 2'd1;
                    retire    = 1'b1;
                end else if (is_jalr) begin
                    ALUsrc    = 1'b1;
                    ResultSrc = 2'd2;
                    RegWrite  = 1'b1;
                    PCwrite   = 1'b1;
                    PCsrc     = 2'd2;
                    retire    = 1'b1;
                end
            end
            S_MEM: begin
                mem_req = 1'b1;
                AdrSrc  = 1'b1;
                mem_we  = is_store;
                ALUsrc  = 1'b1;
                ImmSrc  = is_store ? IMM_S : IMM_I;
                if (is_store && mem_ready) begin
                    PCwrite = 1'b1;
                    retire  = 1'b1;
                end
            end
            S_WB: begin
                RegWrite = 1'b1;
                PCwrite  = 1'b1;
                retire   = 1'b1;
                if (is_load) begin
                    ResultSrc = 2'd1;
                end else if (is_lui) begin
                    ResultSrc = 2'd3;
                    ImmSrc    = IMM_U;
                end else begin
                    ALUctrl = alu_op;
                    ALUsrc  = is_i;
                end
            end
            default: ;
        endcase
    end

    assign state = st;

endmodule
